rnd_dispenser: RTL



---
 rtl/rnd_dispenser.sv | 131 +++++++++++++
 1 files changed

// File: rtl/rnd_dispenser.sv
// Round-robin dispenser of a shared LFSR value, range-reduced to [0, limit) by
// masked rejection sampling with a subtract fallback after MAX_TRIES rejects.
module rnd_dispenser #(
    parameter int unsigned N_REQ     = 2,
    parameter int unsigned RND_W     = 16,
    parameter int unsigned MAX_TRIES = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [RND_W-1:0]       rnd_num_i,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*RND_W-1:0] limit_i,
    output logic [N_REQ-1:0]       gnt_o,
    output logic [RND_W-1:0]       rnd_o,
    output logic                   busy_o
);
    localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned TryW = $clog2(MAX_TRIES + 1);

    typedef enum logic [1:0] {StIdle, StDraw, StGrant} state_e;

    state_e           state_q;
    logic [IdxW-1:0]  ptr_q;
    logic [IdxW-1:0]  idx_q;
    logic [RND_W-1:0] lim_q;
    logic [RND_W-1:0] mask_q;
    logic [TryW-1:0]  try_q;
    logic [N_REQ-1:0] gnt_q;
    logic [RND_W-1:0] rnd_q;
    logic             busy_q;

    logic             pick_vld;
    logic [IdxW-1:0]  pick_idx;
    logic [IdxW-1:0]  cand;
    int unsigned      scan_j;
    logic [RND_W-1:0] lim_sel;
    logic [RND_W-1:0] mask_sel;
    logic [RND_W-1:0] draw_v;
    logic             accept;
    logic             last_try;
    logic [IdxW-1:0]  ptr_next;

    // First asserted request scanning upward from ptr_q, wrapping at N_REQ.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        scan_j   = 0;
        cand     = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            scan_j = 32'(ptr_q) + k;
            if (scan_j >= N_REQ) begin
                scan_j = scan_j - N_REQ;
            end
            cand = IdxW'(scan_j);
            if (!pick_vld && req_i[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // Smear lim-1 rightward: smallest all-ones mask covering every value below lim.
    always_comb begin
        lim_sel  = limit_i[32'(pick_idx)*RND_W +: RND_W];
        mask_sel = lim_sel - RND_W'(1);
        for (int unsigned s = 1; s < RND_W; s = s * 2) begin
            mask_sel = mask_sel | (mask_sel >> s);
        end
    end

    // lim==0 wraps the mask to all ones, so draw_v is the raw value there.
    always_comb begin
        draw_v   = rnd_num_i & mask_q;
        accept   = (lim_q == '0) || (draw_v < lim_q);
        last_try = (try_q == TryW'(MAX_TRIES - 1));
        ptr_next = (idx_q == IdxW'(N_REQ - 1)) ? '0 : idx_q + IdxW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            idx_q   <= '0;
            lim_q   <= '0;
            mask_q  <= '0;
            try_q   <= '0;
            gnt_q   <= '0;
            rnd_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pick_vld) begin
                        idx_q   <= pick_idx;
                        lim_q   <= lim_sel;
                        mask_q  <= mask_sel;
                        try_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StDraw;
                    end
                end
                StDraw: begin
                    if (!req_i[idx_q]) begin
                        busy_q  <= 1'b0;
                        ptr_q   <= ptr_next;
                        state_q <= StIdle;
                    end else if (accept || last_try) begin
                        // Fallback stays in range because mask < 2*lim.
                        rnd_q   <= accept ? draw_v : draw_v - lim_q;
                        gnt_q   <= N_REQ'(1) << idx_q;
                        busy_q  <= 1'b0;
                        state_q <= StGrant;
                    end else begin
                        try_q <= try_q + TryW'(1);
                    end
                end
                StGrant: begin
                    gnt_q   <= '0;
                    ptr_q   <= ptr_next;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign gnt_o  = gnt_q;
    assign rnd_o  = rnd_q;
    assign busy_o = busy_q;

endmodule
